// File: rtl/trans_exec_block.sv
// trans_exec_block: executes single commands as Avalon-MM write/read bursts; optional TRANS_RND_DATA_EN selects LFSR write data
module trans_exec_block #(
    parameter int ADDR_W      = 32,
    parameter int AMM_DATA_W  = 128,
    parameter int AMM_BURST_W = 8
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic                      start_test_i,
    input  logic [AMM_BURST_W-2:0]    burstcount_i,
    input  logic [7:0]                data_pattern_i,
    input  logic                      trans_valid_i,
    input  logic [ADDR_W-1:0]         trans_addr_i,
    input  logic                      trans_type_i,
    output logic                      in_process_o,
    output logic                      trans_busy_o,
    output logic [ADDR_W-1:0]         amm_address_o,
    output logic                      amm_read_o,
    output logic                      amm_write_o,
    output logic [AMM_DATA_W-1:0]     amm_writedata_o,
    output logic [AMM_DATA_W/8-1:0]   amm_byteenable_o,
    output logic [AMM_BURST_W-1:0]    amm_burstcount_o,
    input  logic                      amm_waitrequest_i,
    input  logic                      amm_readdatavalid_i,
    input  logic [AMM_DATA_W-1:0]     amm_readdata_i,
    output logic [AMM_DATA_W-1:0]     rd_data_o,
    output logic                      rd_data_valid_o,
    output logic                      amm_err_o
);
    typedef enum logic [1:0] {IDLE_S, WRITE_S, READ_CMD_S, READ_DATA_S} state_t;
    localparam logic [AMM_BURST_W-2:0] ONE_C = 1;
    localparam logic [AMM_BURST_W-1:0] ONE_B = 1;
    state_t                  state_q;
    logic [ADDR_W-1:0]       addr_q;
    logic [AMM_BURST_W-1:0]  burst_q;
    logic [AMM_BURST_W-2:0]  cnt_q;
    logic                    rd_valid_q;
    logic [AMM_DATA_W-1:0]   rd_data_q;
    logic                    err_q;
    logic [AMM_DATA_W-1:0]   wdata;
    logic                    wr_beat;
    logic                    rd_beat;
    logic                    last;
    assign wr_beat = (state_q == WRITE_S) && !amm_waitrequest_i;
    assign rd_beat = amm_readdatavalid_i && (state_q == READ_CMD_S || state_q == READ_DATA_S);
    assign last    = (cnt_q == '0);
    // Command FSM: latch the command on accept, count beats down to the last one
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE_S;
            addr_q  <= '0;
            burst_q <= '0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE_S: if (trans_valid_i) begin
                    addr_q  <= trans_addr_i;
                    burst_q <= {1'b0, burstcount_i} + ONE_B;
                    cnt_q   <= burstcount_i;
                    state_q <= trans_type_i ? READ_CMD_S : WRITE_S;
                end
                WRITE_S: if (!amm_waitrequest_i) begin
                    cnt_q <= last ? '0 : cnt_q - ONE_C;
                    if (last) state_q <= IDLE_S;
                end
                READ_CMD_S, READ_DATA_S: begin
                    if (amm_readdatavalid_i) cnt_q <= last ? '0 : cnt_q - ONE_C;
                    if (amm_readdatavalid_i && last) state_q <= IDLE_S;
                    else if (state_q == READ_CMD_S && !amm_waitrequest_i) state_q <= READ_DATA_S;
                end
                default: state_q <= IDLE_S;
            endcase
        end
    end
    // Read return: forward only beats belonging to the running read, one cycle late
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            rd_valid_q <= rd_beat;
            if (rd_beat) rd_data_q <= amm_readdata_i;
        end
    end
    // Sticky error on stray readdatavalid; setting wins over the start-test clear
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) err_q <= 1'b0;
        else if (amm_readdatavalid_i && !rd_beat) err_q <= 1'b1;
        else if (start_test_i) err_q <= 1'b0;
    end
`ifdef TRANS_RND_DATA_EN
    logic [31:0] lfsr_q;
    // Pattern LFSR x^32+x^22+x^2+x+1, advanced once per accepted write beat
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) lfsr_q <= '0;
        else if (start_test_i) lfsr_q <= {4{data_pattern_i}};
        else if (wr_beat) lfsr_q <= {lfsr_q[30:0], lfsr_q[31] ^ lfsr_q[21] ^ lfsr_q[1] ^ lfsr_q[0]};
    end
    assign wdata = {(AMM_DATA_W/32){lfsr_q}};
`else
    assign wdata = {(AMM_DATA_W/8){data_pattern_i}};
`endif
    assign in_process_o     = (state_q != IDLE_S);
    assign amm_write_o      = (state_q == WRITE_S);
    assign amm_read_o       = (state_q == READ_CMD_S);
    assign amm_writedata_o  = amm_write_o ? wdata : '0;
    assign amm_byteenable_o = (amm_write_o || amm_read_o) ? '1 : '0;
    assign amm_address_o    = addr_q;
    assign amm_burstcount_o = burst_q;
    assign rd_data_o        = rd_data_q;
    assign rd_data_valid_o  = rd_valid_q;
    assign amm_err_o        = err_q;
    assign trans_busy_o     = in_process_o | rd_valid_q;
endmodule

// File: tb/tb_trans_exec_block.sv
// tb_trans_exec_block: randomized bursts against a beat-level reference model of the executor
module tb_trans_exec_block;
    logic         clk = 0, rst = 1, start_test = 0, trans_valid = 0, trans_type = 0;
    logic [6:0]   burstcount = 0;
    logic [7:0]   data_pattern = 0;
    logic [31:0]  trans_addr = 0;
    logic         in_process, trans_busy, amm_read, amm_write, amm_err, rd_data_valid;
    logic [31:0]  amm_address;
    logic [127:0] amm_writedata, amm_readdata = 0, rd_data;
    logic [15:0]  amm_byteenable;
    logic [7:0]   amm_burstcount;
    logic         amm_waitrequest = 0, amm_readdatavalid = 0;
    int           pass_cnt = 0, tot_cnt = 0;

    trans_exec_block dut (
        .clk_i(clk), .rst_i(rst), .start_test_i(start_test), .burstcount_i(burstcount),
        .data_pattern_i(data_pattern), .trans_valid_i(trans_valid), .trans_addr_i(trans_addr),
        .trans_type_i(trans_type), .in_process_o(in_process), .trans_busy_o(trans_busy),
        .amm_address_o(amm_address), .amm_read_o(amm_read), .amm_write_o(amm_write),
        .amm_writedata_o(amm_writedata), .amm_byteenable_o(amm_byteenable),
        .amm_burstcount_o(amm_burstcount), .amm_waitrequest_i(amm_waitrequest),
        .amm_readdatavalid_i(amm_readdatavalid), .amm_readdata_i(amm_readdata),
        .rd_data_o(rd_data), .rd_data_valid_o(rd_data_valid), .amm_err_o(amm_err)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1;
        repeat (2) @(negedge clk);
        tot_cnt++;
        if ({in_process, trans_busy, amm_read, amm_write, amm_address, amm_writedata, amm_byteenable, amm_burstcount, rd_data, rd_data_valid, amm_err} !== '0)
            $display("FAIL reset_outputs got in_process=%b write=%b read=%b addr=%h burst=%h err=%b want all zero", in_process, amm_write, amm_read, amm_address, amm_burstcount, amm_err);
        else pass_cnt++;
        rst = 0;
        @(negedge clk);
    endtask

    task automatic test_write(input int n, input logic [31:0] a, input logic [7:0] p, input int wpct);
        int beats = 0;
        logic w;
        trans_valid = 1; trans_type = 0; trans_addr = a; burstcount = 7'(n - 1); data_pattern = p;
        @(negedge clk);
        trans_valid = 0;
        while (beats < n) begin
            tot_cnt++;
            if ({in_process, amm_write, amm_read, amm_address, amm_burstcount, amm_writedata, amm_byteenable} !== {2'b11, 1'b0, a, 8'(n), {16{p}}, 16'hFFFF})
                $display("FAIL write_beat%0d got ip=%b wr=%b rd=%b addr=%h burst=%h data=%h be=%h want addr=%h burst=%h data=%h", beats, in_process, amm_write, amm_read, amm_address, amm_burstcount, amm_writedata, amm_byteenable, a, 8'(n), {16{p}});
            else pass_cnt++;
            w = ($urandom_range(99) < wpct);
            amm_waitrequest = w;
            if (!w) beats++;
            @(negedge clk);
        end
        amm_waitrequest = 0;
        tot_cnt++;
        if ({in_process, amm_write, amm_byteenable, amm_writedata} !== '0)
            $display("FAIL write_end got ip=%b wr=%b be=%h want 0 0 0", in_process, amm_write, amm_byteenable);
        else pass_cnt++;
    endtask

    task automatic test_read(input int n, input logic [31:0] a);
        int beats = 0;
        logic cmd_done = 0, done_next, pv = 0;
        logic [127:0] pd = 0;
        trans_valid = 1; trans_type = 1; trans_addr = a; burstcount = 7'(n - 1);
        @(negedge clk);
        trans_valid = 0;
        while (beats < n) begin
            tot_cnt++;
            if ({in_process, amm_read, amm_write, amm_address, amm_burstcount, amm_byteenable} !== {1'b1, !cmd_done, 1'b0, a, 8'(n), {16{!cmd_done}}})
                $display("FAIL read_cycle got ip=%b rd=%b wr=%b addr=%h burst=%h be=%h want rd=%b addr=%h burst=%h", in_process, amm_read, amm_write, amm_address, amm_burstcount, amm_byteenable, !cmd_done, a, 8'(n));
            else pass_cnt++;
            tot_cnt++;
            if (rd_data_valid !== pv) $display("FAIL read_valid got %b want %b", rd_data_valid, pv);
            else pass_cnt++;
            if (pv) begin
                tot_cnt++;
                if (rd_data !== pd) $display("FAIL read_data got %h want %h", rd_data, pd);
                else pass_cnt++;
            end
            done_next = 0;
            amm_readdatavalid = 0;
            if (!cmd_done) begin
                amm_waitrequest = ($urandom_range(99) < 40);
                done_next = !amm_waitrequest;
            end else begin
                amm_waitrequest = 0;
                amm_readdatavalid = ($urandom_range(99) < 60);
                amm_readdata = {$urandom, $urandom, $urandom, $urandom};
                if (amm_readdatavalid) beats++;
            end
            pv = amm_readdatavalid; pd = amm_readdata;
            @(negedge clk);
            cmd_done = cmd_done | done_next;
        end
        amm_readdatavalid = 0; amm_waitrequest = 0;
        tot_cnt++;
        if ({in_process, rd_data_valid, trans_busy, rd_data} !== {3'b011, pd})
            $display("FAIL read_last got ip=%b v=%b busy=%b data=%h want 0 1 1 %h", in_process, rd_data_valid, trans_busy, rd_data, pd);
        else pass_cnt++;
        @(negedge clk);
        tot_cnt++;
        if ({rd_data_valid, trans_busy, amm_err} !== 3'b000)
            $display("FAIL read_after got v=%b busy=%b err=%b want 0 0 0", rd_data_valid, trans_busy, amm_err);
        else pass_cnt++;
    endtask

    task automatic test_back_to_back();
        int n1 = $urandom_range(1, 6), n2 = $urandom_range(1, 6);
        logic [31:0] a1 = $urandom, a2 = $urandom;
        trans_valid = 1; trans_type = 0; trans_addr = a1; burstcount = 7'(n1 - 1); data_pattern = 8'h3C;
        @(negedge clk);
        trans_addr = a2; burstcount = 7'(n2 - 1);
        for (int i = 0; i < n1; i++) begin
            tot_cnt++;
            if ({in_process, amm_write, amm_address, amm_burstcount} !== {2'b11, a1, 8'(n1)})
                $display("FAIL b2b_first got ip=%b wr=%b addr=%h burst=%h want addr=%h burst=%h", in_process, amm_write, amm_address, amm_burstcount, a1, 8'(n1));
            else pass_cnt++;
            @(negedge clk);
        end
        tot_cnt++;
        if (in_process !== 1'b0) $display("FAIL b2b_gap got ip=%b want 0", in_process);
        else pass_cnt++;
        @(negedge clk);
        trans_valid = 0;
        for (int i = 0; i < n2; i++) begin
            tot_cnt++;
            if ({in_process, amm_write, amm_address, amm_burstcount} !== {2'b11, a2, 8'(n2)})
                $display("FAIL b2b_second got ip=%b wr=%b addr=%h burst=%h want addr=%h burst=%h", in_process, amm_write, amm_address, amm_burstcount, a2, 8'(n2));
            else pass_cnt++;
            @(negedge clk);
        end
        repeat (2) begin
            tot_cnt++;
            if ({in_process, amm_write} !== 2'b00) $display("FAIL b2b_no_dup got ip=%b wr=%b want 0 0", in_process, amm_write);
            else pass_cnt++;
            @(negedge clk);
        end
    endtask

    task automatic test_stray_data();
        amm_readdatavalid = 1; amm_readdata = {$urandom, $urandom, $urandom, $urandom};
        @(negedge clk);
        amm_readdatavalid = 0;
        tot_cnt++;
        if ({amm_err, rd_data_valid, trans_busy} !== 3'b100) $display("FAIL stray_set got err=%b v=%b busy=%b want 1 0 0", amm_err, rd_data_valid, trans_busy);
        else pass_cnt++;
        repeat (3) @(negedge clk);
        tot_cnt++;
        if (amm_err !== 1'b1) $display("FAIL stray_sticky got %b want 1", amm_err);
        else pass_cnt++;
        start_test = 1;
        @(negedge clk);
        start_test = 0;
        tot_cnt++;
        if (amm_err !== 1'b0) $display("FAIL stray_clear got %b want 0", amm_err);
        else pass_cnt++;
        start_test = 1; amm_readdatavalid = 1;
        @(negedge clk);
        start_test = 0; amm_readdatavalid = 0;
        tot_cnt++;
        if (amm_err !== 1'b1) $display("FAIL stray_priority got %b want 1", amm_err);
        else pass_cnt++;
        start_test = 1;
        @(negedge clk);
        start_test = 0;
        tot_cnt++;
        if (amm_err !== 1'b0) $display("FAIL stray_clear2 got %b want 0", amm_err);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_write();
        trans_valid = 1; trans_type = 0; trans_addr = 32'hDEAD_BEE0; burstcount = 7'd7; data_pattern = 8'h5A;
        @(negedge clk);
        trans_valid = 0;
        repeat (3) @(negedge clk);
        rst = 1;
        #1;
        tot_cnt++;
        if ({in_process, trans_busy, amm_read, amm_write, amm_address, amm_writedata, amm_byteenable, amm_burstcount, rd_data, rd_data_valid, amm_err} !== '0)
            $display("FAIL reset_mid_write got ip=%b wr=%b addr=%h burst=%h be=%h want all zero", in_process, amm_write, amm_address, amm_burstcount, amm_byteenable);
        else pass_cnt++;
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        test_write(5, 32'h0000_0200, 8'hC3, 30);
    endtask

    initial begin
        test_reset();
        test_write(4, 32'h0000_0100, 8'hA5, 0);
        test_write(1, $urandom, 8'($urandom), 30);
        test_write(128, $urandom, 8'($urandom), 20);
        for (int i = 0; i < 4; i++) test_write($urandom_range(1, 16), $urandom, 8'($urandom), 40);
        test_read(3, 32'h0000_0400);
        test_read(1, $urandom);
        for (int i = 0; i < 4; i++) test_read($urandom_range(1, 16), $urandom);
        test_back_to_back();
        test_stray_data();
        test_reset_mid_write();
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end
endmodule
